// File: rtl/risc_pkg.sv
// Shared types for the RISC memory arbiter: FSM state (which doubles as the
// bus owner), last-served flag encoding and the tie-break helper.
package risc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      LDR  = 2'd2
   } arb_state_t;

   localparam logic LAST_CPU = 1'b0;
   localparam logic LAST_LDR = 1'b1;

   // On a tie the requester that was not served last wins.
   function automatic arb_state_t arbitrate(input logic cpu_req,
                                            input logic ld_req,
                                            input logic last_served);
      if (cpu_req && ld_req) return (last_served == LAST_CPU) ? LDR : CPU;
      if (cpu_req)           return CPU;
      if (ld_req)            return LDR;
      return IDLE;
   endfunction

endpackage

// File: rtl/risc_mem_arbiter_counter.sv
// Generic up-counter with synchronous clear, parallel load and count enable.
module Counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             enab,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       count <= '0;
      else if (clear) count <= '0;
      else if (load)  count <= din;
      else if (enab)  count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Two-master (CPU single beats, loader bursts) arbiter for one shared memory port.
// Define RISC_ARB_RR_EN for round-robin tie-breaking; default is fixed CPU priority.
module risc_mem_arbiter
   import risc_pkg::*;
#(
   parameter int AWIDTH    = 5,
   parameter int DWIDTH    = 8,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic [DWIDTH-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_wr,
   input  logic              ld_last,
   input  logic [AWIDTH-1:0] ld_addr,
   input  logic [DWIDTH-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic [DWIDTH-1:0] ld_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

   arb_state_t    state;
   arb_state_t    next_state;
   arb_state_t    arb_win;
   logic [CW-1:0] beat_cnt;
   logic          ld_beat;
   logic          last_beat;
   logic          ldr_entry;

   // beat_cnt holds beats already done, so LAST_CNT marks the MAX_BURST-th beat.
   assign ld_beat   = (state == LDR) && ld_req;
   assign last_beat = ld_last || (beat_cnt == LAST_CNT);
   assign ldr_entry = (next_state == LDR) && (state != LDR);

   Counter #(.WIDTH(CW)) u_beat_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (ldr_entry),
      .load  (1'b0),
      .enab  (ld_beat),
      .din   (CW'(0)),
      .count (beat_cnt)
   );

`ifdef RISC_ARB_RR_EN
   logic last_served;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   last_served <= LAST_CPU;
      else if (next_state == CPU) last_served <= LAST_CPU;
      else if (next_state == LDR) last_served <= LAST_LDR;
   end

   assign arb_win = arbitrate(cpu_req, ld_req, last_served);
`else
   // Pretending the loader was always served last makes the CPU win every tie.
   assign arb_win = arbitrate(cpu_req, ld_req, LAST_LDR);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // A released loader never regrabs the bus directly; it re-arbitrates from IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, CPU: next_state = arb_win;
         LDR:       if (!ld_req || last_beat) next_state = cpu_req ? CPU : IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      cpu_gnt   = 1'b0;
      ld_gnt    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      ld_rdata  = '0;
      case (state)
         CPU: begin
            cpu_gnt   = 1'b1;
            mem_rd    = cpu_req & ~cpu_wr;
            mem_wr    = cpu_req & cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
         end
         LDR: begin
            ld_gnt    = 1'b1;
            mem_rd    = ld_req & ~ld_wr;
            mem_wr    = ld_req & ld_wr;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            ld_rdata  = mem_rdata;
         end
         default: ;
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Self-checking bench for risc_mem_arbiter: directed scenarios driven through small
// CPU/loader master models, with queued expected memory traffic. Honours RISC_ARB_RR_EN.
module tb_risc_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int MB = 8;

   logic          clk;
   logic          rst;
   logic          cpu_req;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_stall;
   logic [DW-1:0] cpu_rdata;
   logic          ld_req;
   logic          ld_wr;
   logic          ld_last;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt;
   logic [DW-1:0] ld_rdata;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           wr_q[$];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] mem [2**AW];

   int checks   = 0;
   int failures = 0;

   logic          cpu_pend;
   logic          cpu_hold;
   logic          cpu_wr_v;
   logic [AW-1:0] cpu_addr_v;
   logic [DW-1:0] cpu_wdata_v;
   logic          ld_active;
   logic          ld_wr_v;
   logic          ld_use_last;
   logic          ld_repeat;
   logic [AW-1:0] ld_base;
   int            ld_idx;
   int            ld_n;
   logic          sb_on;

   logic [31:0]   cpu_vec;
   logic [31:0]   ld_vec;
   logic [31:0]   stall_vec;
   logic [31:0]   wr_vec;
   int            log_n;

   logic [5:0]    exp_cpu;
   logic [5:0]    exp_ld;
   logic [5:0]    exp_stall;

   assign mem_rdata = mem[mem_addr];

   risc_mem_arbiter #(
      .AWIDTH    (AW),
      .DWIDTH    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_stall (cpu_stall),
      .cpu_rdata (cpu_rdata),
      .ld_req    (ld_req),
      .ld_wr     (ld_wr),
      .ld_last   (ld_last),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_gnt    (ld_gnt),
      .ld_rdata  (ld_rdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_inputs();
      cpu_req   = cpu_pend;
      cpu_wr    = cpu_wr_v;
      cpu_addr  = cpu_addr_v;
      cpu_wdata = cpu_wdata_v;
      ld_req    = ld_active;
      ld_wr     = ld_wr_v;
      ld_addr   = ld_base + AW'(ld_idx);
      ld_wdata  = DW'(8'h30 + ld_idx);
      ld_last   = ld_active && ld_use_last && (ld_idx == ld_n - 1);
   endtask

   // Runs at the falling edge: scoreboard, grant log, then master bookkeeping.
   task automatic monitor();
      wr_t exp_wr;
      logic [DW-1:0] exp_rd;
      if (sb_on && mem_wr) begin
         check_output("wr_sb_pending", (wr_q.size() != 0), 1);
         if (wr_q.size() != 0) begin
            exp_wr = wr_q.pop_front();
            check_output("wr_addr", mem_addr, exp_wr.addr);
            check_output("wr_data", mem_wdata, exp_wr.data);
         end
      end
      if (sb_on && mem_rd && cpu_gnt) begin
         check_output("rd_sb_pending", (rd_q.size() != 0), 1);
         if (rd_q.size() != 0) begin
            exp_rd = rd_q.pop_front();
            check_output("cpu_rdata", cpu_rdata, exp_rd);
         end
      end
      if (log_n < 32) begin
         cpu_vec[log_n]   = cpu_gnt;
         ld_vec[log_n]    = ld_gnt;
         stall_vec[log_n] = cpu_stall;
         wr_vec[log_n]    = mem_wr;
         log_n++;
      end
      if (cpu_gnt && cpu_req && !cpu_hold) begin
         cpu_pend = 1'b0;
         cpu_req  = 1'b0;
      end
      if (ld_gnt && ld_req) begin
         ld_idx++;
         if (ld_idx == ld_n) begin
            if (ld_repeat) ld_idx = 0;
            else           ld_active = 1'b0;
         end
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive_inputs();
         @(negedge clk);
         monitor();
      end
   endtask

   task automatic clear_logs();
      cpu_vec   = '0;
      ld_vec    = '0;
      stall_vec = '0;
      wr_vec    = '0;
      log_n     = 0;
   endtask

   task automatic start_loader(input logic [AW-1:0] base, input int n,
                               input logic use_last, input logic rpt);
      ld_base     = base;
      ld_n        = n;
      ld_use_last = use_last;
      ld_repeat   = rpt;
      ld_idx      = 0;
      ld_wr_v     = 1'b1;
      ld_active   = 1'b1;
   endtask

   task automatic push_ld_writes(input logic [AW-1:0] base, input int count);
      for (int i = 0; i < count; i++)
         wr_q.push_back('{addr: base + AW'(i), data: DW'(8'h30 + i)});
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = DW'(8'hA0 + i);
      cpu_pend = 1'b0; cpu_hold = 1'b0; cpu_wr_v = 1'b0;
      cpu_addr_v = '0; cpu_wdata_v = '0;
      ld_active = 1'b0; ld_wr_v = 1'b0; ld_use_last = 1'b0; ld_repeat = 1'b0;
      ld_base = '0; ld_idx = 0; ld_n = 1; sb_on = 1'b1;
      clear_logs();

      rst = 1'b0;
      drive_inputs();
      cpu_req = 1'b1;
      ld_req  = 1'b1;
      repeat (2) @(negedge clk);
      check_output("rst_cpu_gnt", cpu_gnt, 0);
      check_output("rst_ld_gnt", ld_gnt, 0);
      check_output("rst_mem_rd", mem_rd, 0);
      check_output("rst_mem_wr", mem_wr, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_cpu_rdata", cpu_rdata, 0);
      check_output("rst_ld_rdata", ld_rdata, 0);
      check_output("rst_cpu_stall", cpu_stall, 1);
      drive_inputs();
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] single CPU read at address 5");
      cpu_pend = 1'b1; cpu_wr_v = 1'b0; cpu_addr_v = 5'd5;
      rd_q.push_back(8'hA5);
      clear_logs();
      run_cycles(3);
      check_output("cpu_read_gnt", cpu_vec[2:0], 3'b010);
      check_output("cpu_read_stall", stall_vec[2:0], 3'b001);
      check_output("cpu_read_ld_gnt", ld_vec[2:0], 3'b000);
      check_output("cpu_read_done", rd_q.size(), 0);

      $display("[TB] single CPU write");
      cpu_pend = 1'b1; cpu_wr_v = 1'b1; cpu_addr_v = 5'h1F; cpu_wdata_v = 8'h5A;
      wr_q.push_back('{addr: 5'h1F, data: 8'h5A});
      clear_logs();
      run_cycles(3);
      check_output("cpu_write_strobe", wr_vec[2:0], 3'b010);
      check_output("cpu_write_done", wr_q.size(), 0);
      cpu_wr_v = 1'b0;

      $display("[TB] loader burst of 4 with ld_last");
      start_loader(5'd0, 4, 1'b1, 1'b0);
      push_ld_writes(5'd0, 4);
      clear_logs();
      run_cycles(7);
      check_output("burst4_ld_gnt", ld_vec[6:0], 7'b0011110);
      check_output("burst4_mem_wr", wr_vec[6:0], 7'b0011110);
      check_output("burst4_done", wr_q.size(), 0);

      $display("[TB] loader burst without ld_last, capped at MAX_BURST");
      start_loader(5'd8, 10, 1'b0, 1'b0);
      push_ld_writes(5'd8, 10);
      clear_logs();
      run_cycles(14);
      check_output("cap_ld_gnt", ld_vec[13:0], 14'b01110111111110);
      check_output("cap_mem_wr", wr_vec[13:0], 14'b00110111111110);
      check_output("cap_done", wr_q.size(), 0);

      $display("[TB] CPU request during beat 2 of an 8-beat burst");
      start_loader(5'd0, 8, 1'b0, 1'b0);
      push_ld_writes(5'd0, 8);
      clear_logs();
      run_cycles(2);
      cpu_pend = 1'b1; cpu_wr_v = 1'b0; cpu_addr_v = 5'd3;
      rd_q.push_back(8'hA3);
      run_cycles(10);
      check_output("wait_ld_gnt", ld_vec[11:0], 12'b000111111110);
      check_output("wait_cpu_gnt", cpu_vec[11:0], 12'b001000000000);
      check_output("wait_cpu_stall", stall_vec[11:0], 12'b000111111100);
      check_output("wait_done", wr_q.size() + rd_q.size(), 0);

      $display("[TB] continuous simultaneous requests");
`ifdef RISC_ARB_RR_EN
      exp_cpu = 6'b010100; exp_ld = 6'b101010; exp_stall = 6'b101011;
`else
      exp_cpu = 6'b111110; exp_ld = 6'b000000; exp_stall = 6'b000001;
`endif
      sb_on = 1'b0;
      cpu_pend = 1'b1; cpu_hold = 1'b1; cpu_wr_v = 1'b0; cpu_addr_v = 5'd1;
      start_loader(5'd2, 1, 1'b1, 1'b1);
      ld_wr_v = 1'b0;
      clear_logs();
      run_cycles(6);
      check_output("tie_cpu_gnt", cpu_vec[5:0], exp_cpu);
      check_output("tie_ld_gnt", ld_vec[5:0], exp_ld);
      check_output("tie_cpu_stall", stall_vec[5:0], exp_stall);
      cpu_hold = 1'b0; cpu_pend = 1'b0; ld_active = 1'b0; ld_repeat = 1'b0;
      run_cycles(2);
      sb_on = 1'b1;

      $display("[TB] reset in the middle of a loader burst");
      start_loader(5'h10, 8, 1'b0, 1'b0);
      push_ld_writes(5'h10, 3);
      clear_logs();
      run_cycles(4);
      check_output("abort_pre_beats", wr_vec[3:0], 4'b1110);
      ld_active = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_output("abort_ld_gnt", ld_gnt, 0);
      check_output("abort_mem_wr", mem_wr, 0);
      check_output("abort_cpu_gnt", cpu_gnt, 0);
      check_output("abort_writes", wr_q.size(), 0);
      repeat (2) @(negedge clk);
      check_output("abort_hold_ld_gnt", ld_gnt, 0);
      check_output("abort_hold_addr", mem_addr, 0);
      start_loader(5'h18, 2, 1'b1, 1'b0);
      push_ld_writes(5'h18, 2);
      drive_inputs();
      rst = 1'b1;
      clear_logs();
      run_cycles(4);
      check_output("resume_ld_gnt", ld_vec[3:0], 4'b0011);
      check_output("resume_mem_wr", wr_vec[3:0], 4'b0011);

      check_output("final_wr_queue", wr_q.size(), 0);
      check_output("final_rd_queue", rd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
